// File: rtl/axil_fifo_push_master.sv
// rtl/axil_fifo_push_master.sv - AXI4-Lite initiator pushing words into the async-FIFO slave
module axil_fifo_push_master #(
    parameter int MAX_RETRY = 4,
    parameter int POLL_GAP  = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk_axi,
    input  logic        axi_resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,
    output logic        done_valid,
    output logic [1:0]  done_code,
    output logic [3:0]  done_retries,
    output logic [15:0] push_count,
    output logic        busy,
    output logic [3:0]  awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT_B, S_POLL_GAP, S_POLL_AR, S_POLL_R, S_ERR
    } state_t;

    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [3:0]  ADDR_DATA   = 4'h0;
    localparam logic [3:0]  ADDR_STATUS = 4'h4;

    state_t      state;
    logic [3:0]  retry_cnt;
    logic [31:0] wait_cnt;
    logic        aw_pending;
    logic        w_pending;
    logic        unused_inputs;

    // A channel is still outstanding after this edge if its valid is up without ready.
    assign aw_pending = awvalid & ~awready;
    assign w_pending  = wvalid & ~wready;
    assign busy       = (state != S_IDLE);

    // Only bit 1 of STATUS (full) matters; response codes on R and the OKAY/EXOKAY split on B are don't-care.
    assign unused_inputs = ^{rresp, rdata[31:2], rdata[0], bresp[0]};

    // Main control FSM; all handshake and status outputs are registered here.
    always_ff @(posedge clk_axi) begin
        if (!axi_resetn) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b0;
            done_valid   <= 1'b0;
            done_code    <= 2'd0;
            done_retries <= 4'd0;
            push_count   <= 16'd0;
            awaddr       <= 4'h0;
            awvalid      <= 1'b0;
            wdata        <= 32'd0;
            wstrb        <= 4'd0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            araddr       <= 4'h0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            retry_cnt    <= 4'd0;
            wait_cnt     <= 32'd0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wdata     <= cmd_data;
                        wstrb     <= cmd_strb;
                        retry_cnt <= 4'd0;
                        awaddr    <= ADDR_DATA;
                        awvalid   <= 1'b1;
                        wvalid    <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= S_WRITE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (!aw_pending && !w_pending) begin
                        bready   <= 1'b1;
                        wait_cnt <= 32'd0;
                        state    <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (!bresp[1]) begin
                            push_count   <= push_count + 16'd1;
                            done_valid   <= 1'b1;
                            done_code    <= 2'd0;
                            done_retries <= retry_cnt;
                            cmd_ready    <= 1'b1;
                            state        <= S_IDLE;
                        end else if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            araddr    <= ADDR_STATUS;
                            arvalid   <= 1'b1;
                            state     <= S_POLL_AR;
                        end else begin
                            done_valid   <= 1'b1;
                            done_code    <= 2'd1;
                            done_retries <= retry_cnt;
                            cmd_ready    <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        bready       <= 1'b0;
                        done_valid   <= 1'b1;
                        done_code    <= 2'd2;
                        done_retries <= retry_cnt;
                        state        <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_POLL_AR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        wait_cnt <= 32'd0;
                        state    <= S_POLL_R;
                    end
                end
                S_POLL_R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (rdata[1]) begin
                            wait_cnt <= 32'd0;
                            state    <= S_POLL_GAP;
                        end else begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= S_WRITE;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        rready       <= 1'b0;
                        done_valid   <= 1'b1;
                        done_code    <= 2'd3;
                        done_retries <= retry_cnt;
                        state        <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_POLL_GAP: begin
                    if (wait_cnt == GAP_LAST) begin
                        araddr  <= ADDR_STATUS;
                        arvalid <= 1'b1;
                        state   <= S_POLL_AR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_ERR: begin
                    cmd_ready <= 1'b0;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_fifo_push_master.sv
// tb/tb_axil_fifo_push_master.sv - directed self-checking bench for axil_fifo_push_master
module tb_axil_fifo_push_master;

    localparam int MAX_RETRY = 4;
    localparam int POLL_GAP  = 3;
    localparam int TIMEOUT   = 20;

    logic        clk_axi = 1'b0;
    logic        axi_resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = 32'd0;
    logic [3:0]  cmd_strb = 4'd0;
    logic        done_valid;
    logic [1:0]  done_code;
    logic [3:0]  done_retries;
    logic [15:0] push_count;
    logic        busy;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'd0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rvalid = 1'b0;
    logic        rready;

    int checks = 0;
    int errors = 0;

    // slave model configuration and observation
    int          cyc = 0;
    int          aw_lag = 0;
    bit          b_enable = 1'b1;
    int          b_err_left = 0;
    bit          b_err_always = 1'b0;
    int          status_full_left = 0;
    int          w_cnt = 0, aw_cnt = 0, ar_cnt = 0, done_seen = 0;
    int          aw_only_cycles = 0;
    logic [31:0] w_data_last = 32'd0;
    logic [3:0]  w_strb_last = 4'd0;
    logic [3:0]  aw_addr_last = 4'hF;
    logic [3:0]  ar_addr_last = 4'hF;
    int          last_ar_cyc = 0;
    bit          have_prev_ar = 1'b0;
    int          min_ar_gap = 1000;
    bit          bready_prev = 1'b0;
    int          bready_cyc = 0;
    int          done_cyc = 0;

    always #5 clk_axi = ~clk_axi;

    axil_fifo_push_master #(
        .MAX_RETRY(MAX_RETRY), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_axi(clk_axi), .axi_resetn(axi_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .done_valid(done_valid), .done_code(done_code), .done_retries(done_retries),
        .push_count(push_count), .busy(busy),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Slave responder: at each falling edge sets the readies/responses for the next rising edge
    // and logs every handshake that rising edge will complete.
    task automatic slave_loop();
        forever begin
            @(negedge clk_axi);
            cyc++;
            wready = 1'b1;
            if (wvalid) begin
                w_cnt++;
                w_data_last = wdata;
                w_strb_last = wstrb;
            end
            if (awvalid) begin
                if (aw_lag > 0) begin
                    awready = 1'b0;
                    aw_lag--;
                end else begin
                    awready = 1'b1;
                    aw_cnt++;
                    aw_addr_last = awaddr;
                end
            end else begin
                awready = 1'b0;
            end
            if (awvalid && !wvalid) aw_only_cycles++;
            if (bready && b_enable) begin
                bvalid = 1'b1;
                if (b_err_always || b_err_left > 0) begin
                    bresp = 2'b10;
                    if (b_err_left > 0) b_err_left--;
                end else begin
                    bresp = 2'b00;
                end
            end else begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end
            if (bready && !bready_prev) bready_cyc = cyc;
            bready_prev = bready;
            arready = arvalid;
            if (arvalid) begin
                ar_cnt++;
                ar_addr_last = araddr;
                if (have_prev_ar && (cyc - last_ar_cyc) < min_ar_gap) min_ar_gap = cyc - last_ar_cyc;
                last_ar_cyc  = cyc;
                have_prev_ar = 1'b1;
            end
            if (rready) begin
                rvalid = 1'b1;
                if (status_full_left > 0) begin
                    rdata = 32'h2;
                    status_full_left--;
                end else begin
                    rdata = 32'h0;
                end
            end else begin
                rvalid = 1'b0;
                rdata  = 32'h0;
            end
            if (done_valid) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_axi);
        #1;
    endtask

    task automatic push_word(input logic [31:0] data, input logic [3:0] strb);
        int n;
        step();
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_strb  = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: cmd_ready never seen (got 0, required 1)");
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        int start;
        start = done_seen;
        seen  = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done_seen != start) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (done_seen != start) seen = 1'b1;
    endtask

    task automatic do_reset();
        step();
        axi_resetn = 1'b0;
        step();
        step();
        axi_resetn = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
        checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin errors++; $display("FAIL reset_valids: got %b required 00000", {awvalid, wvalid, bready, arvalid, rready}); end
        checks++; if (push_count !== 16'd0) begin errors++; $display("FAIL reset_push_count: got %0d required 0", push_count); end
        checks++; if ({done_valid, done_code, done_retries} !== 7'd0) begin errors++; $display("FAIL reset_done: got %h required 0", {done_valid, done_code, done_retries}); end
        checks++; if ({awaddr, araddr, wdata, wstrb} !== 44'd0) begin errors++; $display("FAIL reset_payload: got %h required 0", {awaddr, araddr, wdata, wstrb}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        axi_resetn = 1'b1;
        step();
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_single_push();
        bit seen;
        int w0, aw0;
        w0 = w_cnt; aw0 = aw_cnt;
        push_word(32'hDEADBEEF, 4'hF);
        wait_done(20, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t1_done_seen: got %b required 1", seen); end
        checks++; if (done_code !== 2'd0) begin errors++; $display("FAIL t1_code: got %0d required 0", done_code); end
        checks++; if (done_retries !== 4'd0) begin errors++; $display("FAIL t1_retries: got %0d required 0", done_retries); end
        checks++; if (w_data_last !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_wdata: got %h required deadbeef", w_data_last); end
        checks++; if (w_strb_last !== 4'hF) begin errors++; $display("FAIL t1_wstrb: got %h required f", w_strb_last); end
        checks++; if (aw_addr_last !== 4'h0) begin errors++; $display("FAIL t1_awaddr: got %h required 0", aw_addr_last); end
        checks++; if ((w_cnt - w0) !== 1 || (aw_cnt - aw0) !== 1) begin errors++; $display("FAIL t1_beats: got w=%0d aw=%0d required 1/1", w_cnt - w0, aw_cnt - aw0); end
        step();
        checks++; if (push_count !== 16'd1) begin errors++; $display("FAIL t1_push_count: got %0d required 1", push_count); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t1_idle: got ready=%b busy=%b required 1/0", cmd_ready, busy); end
    endtask

    task automatic test_aw_lag();
        bit seen;
        int w0, aw0, done0;
        w0 = w_cnt; aw0 = aw_cnt; done0 = done_seen;
        aw_only_cycles = 0;
        aw_lag = 3;
        push_word(32'h12345678, 4'h5);
        wait_done(30, seen);
        step();
        checks++; if (aw_only_cycles !== 3) begin errors++; $display("FAIL t2_aw_only_cycles: got %0d required 3", aw_only_cycles); end
        checks++; if ((w_cnt - w0) !== 1 || (aw_cnt - aw0) !== 1) begin errors++; $display("FAIL t2_beats: got w=%0d aw=%0d required 1/1", w_cnt - w0, aw_cnt - aw0); end
        checks++; if ((done_seen - done0) !== 1 || done_code !== 2'd0) begin errors++; $display("FAIL t2_done: got n=%0d code=%0d required 1/0", done_seen - done0, done_code); end
        checks++; if (w_strb_last !== 4'h5) begin errors++; $display("FAIL t2_wstrb: got %h required 5", w_strb_last); end
        checks++; if (push_count !== 16'd2) begin errors++; $display("FAIL t2_push_count: got %0d required 2", push_count); end
    endtask

    task automatic test_retry_poll();
        bit seen;
        int w0, ar0;
        w0 = w_cnt; ar0 = ar_cnt;
        b_err_left = 1;
        status_full_left = 2;
        have_prev_ar = 1'b0;
        min_ar_gap = 1000;
        push_word(32'hA5A5_0001, 4'hF);
        wait_done(200, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t3_done_seen: got %b required 1", seen); end
        checks++; if ((ar_cnt - ar0) !== 3) begin errors++; $display("FAIL t3_ar_count: got %0d required 3", ar_cnt - ar0); end
        checks++; if (ar_addr_last !== 4'h4) begin errors++; $display("FAIL t3_araddr: got %h required 4", ar_addr_last); end
        checks++; if (min_ar_gap < POLL_GAP) begin errors++; $display("FAIL t3_poll_gap: got %0d required >= %0d", min_ar_gap, POLL_GAP); end
        checks++; if ((w_cnt - w0) !== 2) begin errors++; $display("FAIL t3_writes: got %0d required 2", w_cnt - w0); end
        checks++; if (done_code !== 2'd0 || done_retries !== 4'd1) begin errors++; $display("FAIL t3_done: got code=%0d retries=%0d required 0/1", done_code, done_retries); end
        step();
        checks++; if (push_count !== 16'd3) begin errors++; $display("FAIL t3_push_count: got %0d required 3", push_count); end
    endtask

    task automatic test_retry_exhausted();
        bit seen;
        int w0;
        w0 = w_cnt;
        b_err_always = 1'b1;
        push_word(32'hCAFE_F00D, 4'h3);
        wait_done(400, seen);
        b_err_always = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t4_done_seen: got %b required 1", seen); end
        checks++; if ((w_cnt - w0) !== 5) begin errors++; $display("FAIL t4_writes: got %0d required 5", w_cnt - w0); end
        checks++; if (done_code !== 2'd1 || done_retries !== 4'd4) begin errors++; $display("FAIL t4_done: got code=%0d retries=%0d required 1/4", done_code, done_retries); end
        step();
        checks++; if (push_count !== 16'd3) begin errors++; $display("FAIL t4_push_count: got %0d required 3", push_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t4_idle: got %b required 1", cmd_ready); end
    endtask

    task automatic test_b_timeout();
        bit seen;
        bit err_ok;
        b_enable = 1'b0;
        push_word(32'h0BAD_0BAD, 4'hF);
        wait_done(TIMEOUT + 20, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t5_done_seen: got %b required 1", seen); end
        checks++; if (done_code !== 2'd2) begin errors++; $display("FAIL t5_code: got %0d required 2", done_code); end
        checks++; if ((done_cyc - bready_cyc) !== TIMEOUT) begin errors++; $display("FAIL t5_timeout_len: got %0d required %0d", done_cyc - bready_cyc, TIMEOUT); end
        err_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_ready !== 1'b0 || busy !== 1'b1 || {awvalid, wvalid, bready, arvalid, rready} !== 5'b0) err_ok = 1'b0;
        end
        checks++; if (err_ok !== 1'b1) begin errors++; $display("FAIL t5_err_sticky: got ready=%b busy=%b required 0/1", cmd_ready, busy); end
        do_reset();
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t5_after_reset: got ready=%b busy=%b required 1/0", cmd_ready, busy); end
    endtask

    task automatic test_reset_mid_transfer();
        int n, done0;
        done0 = done_seen;
        b_enable = 1'b0;
        push_word(32'h5555_AAAA, 4'hF);
        n = 0;
        while (!bready && n < 10) begin
            step();
            n++;
        end
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL t6_wait_b: got bready=%b required 1", bready); end
        axi_resetn = 1'b0;
        step();
        checks++; if ({awvalid, wvalid, bready, arvalid, rready, done_valid} !== 6'b0) begin errors++; $display("FAIL t6_valids: got %b required 000000", {awvalid, wvalid, bready, arvalid, rready, done_valid}); end
        step();
        axi_resetn = 1'b1;
        b_enable = 1'b1;
        step();
        step();
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t6_release: got ready=%b busy=%b required 1/0", cmd_ready, busy); end
        checks++; if ((done_seen - done0) !== 0) begin errors++; $display("FAIL t6_no_done: got %0d required 0", done_seen - done0); end
        checks++; if (push_count !== 16'd0) begin errors++; $display("FAIL t6_push_count: got %0d required 0", push_count); end
    endtask

    initial begin
        fork
            slave_loop();
        join_none
        test_reset();
        test_single_push();
        test_aw_lag();
        test_retry_poll();
        test_retry_exhausted();
        test_b_timeout();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
